// File: rtl/mem_rd_seqr_pkg.sv
// Shared definitions for the memory read sequencer: FSM state encoding
// and default geometry/latency constants.
package mem_rd_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;
  // Wide enough for RD_LAT-1 with RD_LAT up to 4
  localparam int LAT_CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_rd_seqr_if.sv
// Memory read port bundle: the sequencer is the master (strobe + address),
// the memory is the slave (returns data RD_LAT cycles after the strobe).
interface mem_rd_seqr_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/mem_rd_seqr_lat_cnt.sv
// Read-latency down-counter: loaded with RD_LAT-1 on issue, decremented
// while waiting; done flags the last wait cycle.
module rd_lat_cnt
  import mem_rd_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [LAT_CNT_W-1:0] LOAD_VAL = LAT_CNT_W'(RD_LAT - 1);

  logic [LAT_CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= LOAD_VAL;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg <= LAT_CNT_W'(1));

endmodule

// File: rtl/mem_rd_seqr.sv
// Single-word memory read sequencer: each accepted step reads the next address
// and presents it on disp_*. Define MEM_RD_STOP_EN to halt at the top address.
module mem_rd_seqr
  import mem_rd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step,
  mem_rd_seqr_if.master       mem,
  output logic [ADDR_W-1:0]   disp_addr,
  output logic [DATA_W-1:0]   disp_data,
  output logic                valid,
  output logic                busy,
  output logic                wrap
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              rd_en_reg;
  logic              valid_reg;
  logic              wrap_reg;
  logic              busy_reg;
  logic [ADDR_W-1:0] disp_addr_reg;
  logic [DATA_W-1:0] disp_data_reg;
  logic              lat_done;
  logic              step_ok;

`ifdef MEM_RD_STOP_EN
  logic stop_reg;
  assign step_ok = step && !stop_reg;
`else
  assign step_ok = step;
`endif

  rd_lat_cnt #(.RD_LAT(RD_LAT)) u_lat_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (state_reg == ISSUE),
    .en    (state_reg == WAIT),
    .done  (lat_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      rd_en_reg     <= 1'b0;
      valid_reg     <= 1'b0;
      wrap_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      disp_addr_reg <= '0;
      disp_data_reg <= '0;
`ifdef MEM_RD_STOP_EN
      stop_reg      <= 1'b0;
`endif
    end else begin
      rd_en_reg <= 1'b0;
      valid_reg <= 1'b0;
      wrap_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Steps arriving outside IDLE are dropped, never queued
          if (step_ok) begin
            state_reg <= ISSUE;
            rd_en_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        ISSUE: begin
          state_reg <= (RD_LAT > 1) ? WAIT : CAPTURE;
        end
        WAIT: begin
          if (lat_done) begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          disp_addr_reg <= ptr_reg;
          disp_data_reg <= mem.rd_data;
          valid_reg     <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
          if (ptr_reg == PTR_MAX) begin
            wrap_reg <= 1'b1;
          end
`ifdef MEM_RD_STOP_EN
          if (ptr_reg == PTR_MAX) begin
            stop_reg <= 1'b1;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
          end
`else
          ptr_reg <= ptr_reg + 1'b1;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem.rd_en   = rd_en_reg;
  assign mem.rd_addr = ptr_reg;
  assign disp_addr   = disp_addr_reg;
  assign disp_data   = disp_data_reg;
  assign valid       = valid_reg;
  assign busy        = busy_reg;
  assign wrap        = wrap_reg;

endmodule

// File: tb/tb_mem_rd_seqr.sv
// Scoreboard bench for mem_rd_seqr: one instance with RD_LAT=1, one with RD_LAT=3,
// each fed by a latency-accurate memory model. Honours MEM_RD_STOP_EN.
`timescale 1ns/1ps
module tb_mem_rd_seqr;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          step_a = 1'b0, step_b = 1'b0;
  logic [AW-1:0] disp_addr_a, disp_addr_b;
  logic [DW-1:0] disp_data_a, disp_data_b;
  logic          valid_a, valid_b, busy_a, busy_b, wrap_a, wrap_b;

  mem_rd_seqr_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
  mem_rd_seqr_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

  mem_rd_seqr #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .step(step_a), .mem(if_a),
    .disp_addr(disp_addr_a), .disp_data(disp_data_a),
    .valid(valid_a), .busy(busy_a), .wrap(wrap_a)
  );

  mem_rd_seqr #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .step(step_b), .mem(if_b),
    .disp_addr(disp_addr_b), .disp_data(disp_data_b),
    .valid(valid_b), .busy(busy_b), .wrap(wrap_b)
  );

  function automatic logic [7:0] memf(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Memory models: data is only meaningful exactly RD_LAT cycles after a strobe
  logic [7:0] pa;
  logic [7:0] pb0, pb1, pb2;
  always @(posedge clk) begin
    pa  <= (if_a.rd_en === 1'b1) ? memf(if_a.rd_addr) : 8'h00;
    pb0 <= (if_b.rd_en === 1'b1) ? memf(if_b.rd_addr) : 8'h00;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign if_a.rd_data = pa;
  assign if_b.rd_data = pb2;

  exp_t ra_q[$], rb_q[$], va_q[$], vb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (if_a.rd_en === 1'b1) begin
      if (ra_q.size() == 0) check_eq("a_rd_en_expected", ra_q.size(), 1);
      else begin
        e = ra_q.pop_front();
        check_eq("a_rd_addr", if_a.rd_addr, e.addr);
        check_eq("a_rd_en_cyc", cyc, e.cyc);
      end
    end
    if (valid_a === 1'b1) begin
      $display("txn a addr=%02h data=%02h wrap=%0b cyc=%0d", disp_addr_a, disp_data_a, wrap_a, cyc);
      if (va_q.size() == 0) check_eq("a_valid_expected", va_q.size(), 1);
      else begin
        e = va_q.pop_front();
        check_eq("a_disp_addr", disp_addr_a, e.addr);
        check_eq("a_disp_data", disp_data_a, e.data);
        check_eq("a_wrap", wrap_a, e.wrap);
        check_eq("a_valid_cyc", cyc, e.cyc);
      end
    end
    if (wrap_a === 1'b1) check_eq("a_wrap_with_valid", valid_a, 1);
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (if_b.rd_en === 1'b1) begin
      if (rb_q.size() == 0) check_eq("b_rd_en_expected", rb_q.size(), 1);
      else begin
        e = rb_q.pop_front();
        check_eq("b_rd_addr", if_b.rd_addr, e.addr);
        check_eq("b_rd_en_cyc", cyc, e.cyc);
      end
    end
    if (valid_b === 1'b1) begin
      $display("txn b addr=%02h data=%02h wrap=%0b cyc=%0d", disp_addr_b, disp_data_b, wrap_b, cyc);
      if (vb_q.size() == 0) check_eq("b_valid_expected", vb_q.size(), 1);
      else begin
        e = vb_q.pop_front();
        check_eq("b_disp_addr", disp_addr_b, e.addr);
        check_eq("b_disp_data", disp_data_b, e.data);
        check_eq("b_wrap", wrap_b, e.wrap);
        check_eq("b_valid_cyc", cyc, e.cyc);
      end
    end
    if (wrap_b === 1'b1) check_eq("b_wrap_with_valid", valid_b, 1);
  end

  // One step on instance A (RD_LAT=1); accept says whether a read must follow
  task automatic step_a_exp(input bit accept, input logic [7:0] addr);
    int n;
    @(posedge clk); #1;
    step_a = 1'b1;
    n = cyc + 1;
    if (accept) begin
      ra_q.push_back('{n, addr, 8'h00, 1'b0});
      va_q.push_back('{n + 2, addr, memf(addr), (addr == 8'hFF)});
    end
    @(posedge clk); #1;
    step_a = 1'b0;
    check_eq("a_busy_after_step", busy_a, accept);
    repeat (4) @(posedge clk);
  endtask

  task automatic step_b_exp(input logic [7:0] addr);
    int n;
    @(posedge clk); #1;
    step_b = 1'b1;
    n = cyc + 1;
    rb_q.push_back('{n, addr, 8'h00, 1'b0});
    vb_q.push_back('{n + 4, addr, memf(addr), (addr == 8'hFF)});
    @(posedge clk); #1;
    step_b = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin : main
    int n;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_a_busy", busy_a, 0);
    check_eq("rst_a_valid", valid_a, 0);
    check_eq("rst_a_wrap", wrap_a, 0);
    check_eq("rst_a_rd_en", if_a.rd_en, 0);
    check_eq("rst_a_rd_addr", if_a.rd_addr, 0);
    check_eq("rst_a_disp_addr", disp_addr_a, 0);
    check_eq("rst_a_disp_data", disp_data_a, 0);
    check_eq("rst_b_busy", busy_b, 0);
    check_eq("rst_b_rd_en", if_b.rd_en, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;

    // Single read at latency 1: address 0 returns 0xA5
    step_a_exp(1'b1, 8'h00);
    check_eq("a_hold_disp_data", disp_data_a, 8'hA5);
    check_eq("a_hold_disp_addr", disp_addr_a, 8'h00);

    // Latency 3, step held for 10 cycles: only two reads are accepted
    @(posedge clk); #1;
    step_b = 1'b1;
    n = cyc + 1;
    rb_q.push_back('{n, 8'h00, 8'h00, 1'b0});
    rb_q.push_back('{n + 5, 8'h01, 8'h00, 1'b0});
    vb_q.push_back('{n + 4, 8'h00, memf(8'h00), 1'b0});
    vb_q.push_back('{n + 9, 8'h01, memf(8'h01), 1'b0});
    repeat (10) @(posedge clk);
    #1 step_b = 1'b0;
    repeat (4) @(posedge clk);
    check_eq("b_burst_pending", vb_q.size(), 0);
    check_eq("b_burst_hold_addr", disp_addr_b, 8'h01);

    // Reset while B sits in WAIT aborts the read; no valid may follow
    @(posedge clk); #1;
    step_b = 1'b1;
    n = cyc + 1;
    rb_q.push_back('{n, 8'h02, 8'h00, 1'b0});
    @(posedge clk); #1;
    step_b = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_eq("midrst_b_busy", busy_b, 0);
    check_eq("midrst_b_valid", valid_b, 0);
    check_eq("midrst_b_wrap", wrap_b, 0);
    check_eq("midrst_b_rd_en", if_b.rd_en, 0);
    check_eq("midrst_b_rd_addr", if_b.rd_addr, 0);
    check_eq("midrst_b_disp_addr", disp_addr_b, 0);
    check_eq("midrst_b_disp_data", disp_data_b, 0);
    check_eq("midrst_a_disp_data", disp_data_a, 0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    check_eq("b_idle_after_rst", busy_b, 0);
    step_b_exp(8'h00);

    // Walk A through the whole address space to the rollover
    for (int i = 0; i < 255; i++) step_a_exp(1'b1, 8'(i));
    step_a_exp(1'b1, 8'hFF);
`ifdef MEM_RD_STOP_EN
    step_a_exp(1'b0, 8'h00);
    step_a_exp(1'b0, 8'h00);
    check_eq("stop_disp_addr", disp_addr_a, 8'hFF);
    check_eq("stop_disp_data", disp_data_a, memf(8'hFF));
    check_eq("stop_rd_addr", if_a.rd_addr, 8'hFF);
`else
    step_a_exp(1'b1, 8'h00);
    check_eq("after_wrap_disp_addr", disp_addr_a, 8'h00);
    check_eq("after_wrap_rd_addr", if_a.rd_addr, 8'h01);
`endif

    repeat (4) @(posedge clk);
    check_eq("ra_q_empty", ra_q.size(), 0);
    check_eq("va_q_empty", va_q.size(), 0);
    check_eq("rb_q_empty", rb_q.size(), 0);
    check_eq("vb_q_empty", vb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
